// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic unit (divider / multiplier-accumulator pair).
package arith_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // Iteration counter width; never below 1 bit so the counter is always declarable.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/multiplicador.sv
// Shift-add multiply-accumulate: P = Q*B + R, one multiplier bit per cycle.
// Rebuilds a dividend from the divider's quotient, divisor and remainder.
module multiplicador
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     Q,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     R,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic                 done
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic              state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     p_q, p_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              last;
  logic [PW-1:0]     acc_sum;

  assign last    = (cnt_q == CNT_LAST);
  // Full 2*WIDTH add: the largest Q*B+R still fits, so no carry-out is kept.
  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Operands are latched here; later changes on Q/B/R are invisible.
        if (start) begin
          acc_d    = {{WIDTH{1'b0}}, R};
          mcand_d  = {{WIDTH{1'b0}}, B};
          mplier_d = Q;
          cnt_d    = '0;
          busy_d   = 1'b1;
        end
      end
      ST_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last) begin
          p_d    = acc_sum;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign P    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_multiplicador.sv
// Self-checking bench for multiplicador: vector table, divider round-trip,
// random ops against an arithmetic model, and multi-cycle corner sequences.
module tb_multiplicador;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  q_s, b_s, r_s;
  logic [PW-1:0] p_o;
  logic          busy_o, done_o;

  int n_total = 0;
  int n_pass  = 0;

  multiplicador #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .Q     (q_s),
    .B     (b_s),
    .R     (r_s),
    .P     (p_o),
    .busy  (busy_o),
    .done  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int q;
    int b;
    int r;
    int exp_p;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int model_p(input int q, input int b, input int r);
    return q * b + r;
  endfunction

  // Called right after a falling edge so the next rising edge samples start.
  task automatic launch(input int q, input int b, input int r);
    start = 1'b1;
    q_s   = W'(q);
    b_s   = W'(b);
    r_s   = W'(r);
  endtask

  // Counts falling edges after the start edge until done is seen (bounded).
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (lat == 0) start = 1'b0;
      lat++;
      if (busy_o) busy_cnt++;
      if (done_o) break;
      if (lat >= 3 * W + 5) break;
    end
  endtask

  task automatic run_op(input string name, input int q, input int b, input int r,
                        input int exp_p, input bit full);
    int lat, bc;
    @(negedge clk);
    launch(q, b, r);
    wait_done(lat, bc);
    chk({name, " P"}, p_o, exp_p);
    chk({name, " latency"}, lat, W + 1);
    if (full) begin
      chk({name, " busy cycles"}, bc, W);
      @(negedge clk);
      chk({name, " done low after"}, done_o, 0);
      chk({name, " P held"}, p_o, exp_p);
    end
  endtask

  initial begin
    vec_t vecs[$];
    int lat, bc, dones, p_at_done;

    vecs.push_back('{q: 3,  b: 4,  r: 1,  exp_p: 13});
    vecs.push_back('{q: 15, b: 15, r: 15, exp_p: 240});
    vecs.push_back('{q: 0,  b: 9,  r: 7,  exp_p: 7});
    vecs.push_back('{q: 9,  b: 0,  r: 0,  exp_p: 0});
    vecs.push_back('{q: 15, b: 15, r: 0,  exp_p: 225});
    vecs.push_back('{q: 1,  b: 1,  r: 0,  exp_p: 1});
    vecs.push_back('{q: 8,  b: 8,  r: 3,  exp_p: 67});
    vecs.push_back('{q: 10, b: 5,  r: 4,  exp_p: 54});

    reset = 1'b1;
    start = 1'b0;
    q_s = '0; b_s = '0; r_s = '0;
    #1;
    chk("reset P", p_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset done", done_o, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle busy", busy_o, 0);

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].q, vecs[i].b, vecs[i].r,
                             vecs[i].exp_p, 1'b1);

    for (int a = 0; a < 16; a++)
      for (int d = 1; d < 16; d++)
        run_op($sformatf("roundtrip A=%0d B=%0d", a, d), a / d, d, a % d, a, 1'b0);

    for (int i = 0; i < 100; i++) begin
      int q, b, r;
      q = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      r = $urandom_range(0, 15);
      run_op($sformatf("rand q=%0d b=%0d r=%0d", q, b, r), q, b, r, model_p(q, b, r), 1'b0);
    end

    // start while busy is dropped and operand changes are ignored
    @(negedge clk);
    launch(2, 3, 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    launch(15, 15, 15);
    @(negedge clk);
    start = 1'b0;
    q_s = 4'd9; b_s = 4'd9; r_s = 4'd9;
    dones = 0;
    p_at_done = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_o) begin
        dones++;
        p_at_done = int'(p_o);
      end
    end
    chk("ignore-busy done count", dones, 1);
    chk("ignore-busy P", p_at_done, 6);
    chk("ignore-busy idle after", busy_o, 0);

    // back-to-back: next start lands in the done cycle
    @(negedge clk);
    launch(2, 2, 0);
    wait_done(lat, bc);
    chk("b2b first done", done_o, 1);
    chk("b2b first P", p_o, 4);
    launch(5, 5, 0);
    wait_done(lat, bc);
    chk("b2b second latency", lat, W + 1);
    chk("b2b second busy cycles", bc, W);
    chk("b2b second P", p_o, 25);
    @(negedge clk);
    chk("b2b done low after", done_o, 0);

    // reset in the middle of an operation
    @(negedge clk);
    launch(7, 7, 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre-reset busy", busy_o, 1);
    #2 reset = 1'b1;
    #1;
    chk("midreset P", p_o, 0);
    chk("midreset busy", busy_o, 0);
    chk("midreset done", done_o, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_o || busy_o) dones++;
    end
    chk("post-reset no activity", dones, 0);
    chk("post-reset P", p_o, 0);
    run_op("after reset", 7, 7, 1, 50, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
